// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register pending scoreboard for the int and float files, stalling on RAW/WAW/capacity.
// Optional WB_BYPASS_EN: same-cycle writeback masks RAW/WAW hazards and frees capacity for the current ID instruction.
module hazard_scoreboard #(
    parameter  int NREGS       = 32,
    parameter  int MAX_PENDING = 4,
    parameter  int NSRC        = 3,
    localparam int RW          = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int CW          = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*RW-1:0]   id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [NSRC-1:0]      id_rs_float,
    input  logic [RW-1:0]        id_rd,
    input  logic                 id_rd_float,
    input  logic                 id_long,
    input  logic                 wb_valid,
    input  logic [RW-1:0]        wb_rd,
    input  logic                 wb_float,
    output logic                 c_sel,
    output logic                 id_stall,
    output logic                 pc_stall,
    output logic [CW-1:0]        pending_cnt
);

    logic [NREGS-1:0] sb_int_r;
    logic [NREGS-1:0] sb_fp_r;
    logic [CW-1:0]    cnt_r;

    logic [NREGS-1:0] sb_int_n_s;
    logic [NREGS-1:0] sb_fp_n_s;
    logic [CW-1:0]    cnt_n_s;

    logic             raw_s;
    logic             waw_s;
    logic             cap_s;
    logic             cap_full_s;
    logic             clr_s;
    logic             hazard_s;
    logic             stall_s;
    logic             issue_s;
    logic             rd_in_range_s;

    // Indices beyond NREGS (non power-of-two files) never name a real register.
    function automatic logic in_range(input logic [RW-1:0] idx);
        return ({{(32-RW){1'b0}}, idx} < 32'(NREGS));
    endfunction

    function automatic logic is_pending(input logic [NREGS-1:0] sb_i,
                                        input logic [NREGS-1:0] sb_f,
                                        input logic             is_float,
                                        input logic [RW-1:0]    idx);
        logic hit;
        if (!in_range(idx)) begin
            hit = 1'b0;
        end else if (is_float) begin
            hit = sb_f[idx];
        end else begin
            hit = sb_i[idx];
        end
        return hit;
    endfunction

`ifdef WB_BYPASS_EN
    function automatic logic wb_match(input logic          wv,
                                      input logic [RW-1:0] wr,
                                      input logic          wf,
                                      input logic          is_float,
                                      input logic [RW-1:0] idx);
        return wv & (wr == idx) & (wf == is_float);
    endfunction
`endif

    // Hazard detection against the current scoreboard and ID operands.
    always_comb begin
        logic [RW-1:0] src_idx;
        logic          src_hit;
        raw_s   = 1'b0;
        src_idx = {RW{1'b0}};
        src_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src_idx = id_rs[i*RW +: RW];
            src_hit = is_pending(sb_int_r, sb_fp_r, id_rs_float[i], src_idx);
`ifdef WB_BYPASS_EN
            src_hit = src_hit & ~wb_match(wb_valid, wb_rd, wb_float, id_rs_float[i], src_idx);
`endif
            raw_s = raw_s | (id_rs_used[i] & src_hit);
        end

        waw_s = id_long & is_pending(sb_int_r, sb_fp_r, id_rd_float, id_rd);
`ifdef WB_BYPASS_EN
        waw_s = waw_s & ~wb_match(wb_valid, wb_rd, wb_float, id_rd_float, id_rd);
`endif

        clr_s      = wb_valid & is_pending(sb_int_r, sb_fp_r, wb_float, wb_rd);
        cap_full_s = (cnt_r == CW'(MAX_PENDING));
`ifdef WB_BYPASS_EN
        cap_s = id_long & cap_full_s & ~clr_s;
`else
        cap_s = id_long & cap_full_s;
`endif

        hazard_s = id_valid & (raw_s | waw_s | cap_s);
        if (rst_n) begin
            stall_s = hazard_s;
        end else begin
            stall_s = 1'b0;
        end

        rd_in_range_s = in_range(id_rd);
        issue_s = id_valid & id_long & ~hazard_s & rd_in_range_s
                & ~(~id_rd_float & (id_rd == {RW{1'b0}}));
    end

    // Next scoreboard state: clear first so a same-register set wins.
    always_comb begin
        sb_int_n_s = sb_int_r;
        sb_fp_n_s  = sb_fp_r;
        if (clr_s) begin
            if (wb_float) begin
                sb_fp_n_s[wb_rd] = 1'b0;
            end else begin
                sb_int_n_s[wb_rd] = 1'b0;
            end
        end else begin
            sb_int_n_s = sb_int_n_s;
        end
        if (issue_s) begin
            if (id_rd_float) begin
                sb_fp_n_s[id_rd] = 1'b1;
            end else begin
                sb_int_n_s[id_rd] = 1'b1;
            end
        end else begin
            sb_fp_n_s = sb_fp_n_s;
        end
        sb_int_n_s[0] = 1'b0;

        case ({issue_s, clr_s})
            2'b10:   cnt_n_s = cnt_r + CW'(1);
            2'b01:   cnt_n_s = cnt_r - CW'(1);
            default: cnt_n_s = cnt_r;
        endcase
    end

    // Scoreboard and outstanding-op counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_int_r <= {NREGS{1'b0}};
            sb_fp_r  <= {NREGS{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            sb_int_r <= sb_int_n_s;
            sb_fp_r  <= sb_fp_n_s;
            cnt_r    <= cnt_n_s;
        end
    end

    assign c_sel       = stall_s;
    assign id_stall    = stall_s;
    assign pc_stall    = stall_s;
    assign pending_cnt = cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed test-plan scenarios plus randomized traffic vs a pending-set model.
module tb_hazard_scoreboard;
    localparam int NREGS = 32;
    localparam int MAXP  = 4;
    localparam int NSRC  = 3;
    localparam int RW    = 5;
    localparam int CW    = 3;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [NSRC*RW-1:0] id_rs = '0;
    logic [NSRC-1:0]   id_rs_used = '0;
    logic [NSRC-1:0]   id_rs_float = '0;
    logic [RW-1:0]     id_rd = '0;
    logic              id_rd_float = 1'b0;
    logic              id_long = 1'b0;
    logic              wb_valid = 1'b0;
    logic [RW-1:0]     wb_rd = '0;
    logic              wb_float = 1'b0;
    logic              c_sel, id_stall, pc_stall;
    logic [CW-1:0]     pending_cnt;

    hazard_scoreboard #(.NREGS(NREGS), .MAX_PENDING(MAXP), .NSRC(NSRC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rs_float(id_rs_float), .id_rd(id_rd),
        .id_rd_float(id_rd_float), .id_long(id_long), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_float(wb_float), .c_sel(c_sel), .id_stall(id_stall),
        .pc_stall(pc_stall), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit stall; int cnt; } exp_t;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   pend [0:1][0:NREGS-1];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk_stall(input string name, input bit want);
        #1;
        chk(name, {29'd0, c_sel, id_stall, pc_stall}, want ? 32'd7 : 32'd0);
    endtask

    task automatic chk_cnt(input string name, input int want);
        #1;
        chk(name, {29'd0, pending_cnt}, want);
    endtask

    function automatic int pcount();
        int n = 0;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NREGS; r++)
                n += pend[f][r];
        return n;
    endfunction

    function automatic bit masked(input bit f, input bit [4:0] r, input bit wbv,
                                  input bit [4:0] wr, input bit wf);
        return BYP && wbv && (wr == r) && (wf == f);
    endfunction

    function automatic logic [14:0] pk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    // Drive one cycle of inputs, queue the expected response, advance the model.
    task automatic apply(input bit v, input bit [14:0] rs, input bit [2:0] used, input bit [2:0] rsf,
                         input bit [4:0] rd, input bit rdf, input bit lng,
                         input bit wbv, input bit [4:0] wr, input bit wf, input bit rstn);
        exp_t e;
        bit raw, waw, cap, clr, stall, issue;
        int cnt;
        id_valid = v; id_rs = rs; id_rs_used = used; id_rs_float = rsf;
        id_rd = rd; id_rd_float = rdf; id_long = lng;
        wb_valid = wbv; wb_rd = wr; wb_float = wf; rst_n = rstn;

        cnt = pcount();
        clr = wbv && pend[wf][wr];
        raw = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            bit [4:0] r;
            r = rs[i*5 +: 5];
            if (used[i] && pend[rsf[i]][r] && !masked(rsf[i], r, wbv, wr, wf)) raw = 1'b1;
        end
        waw = lng && pend[rdf][rd] && !masked(rdf, rd, wbv, wr, wf);
        cap = lng && (cnt == MAXP) && !(BYP && clr);
        stall = rstn && v && (raw || waw || cap);
        e.stall = stall;
        e.cnt = cnt;
        exp_q.push_back(e);

        if (!rstn) begin
            for (int f = 0; f < 2; f++)
                for (int r = 0; r < NREGS; r++)
                    pend[f][r] = 1'b0;
        end else begin
            issue = v && lng && !stall && !(!rdf && rd == 5'd0);
            if (clr) pend[wf][wr] = 1'b0;
            if (issue) pend[rdf][rd] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 15'd0, 3'd0, 3'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1);
    endtask

    task automatic wb(input bit [4:0] r, input bit f);
        apply(0, 15'd0, 3'd0, 3'd0, 5'd0, 0, 0, 1, r, f, 1);
    endtask

    task automatic issue_op(input bit [4:0] r, input bit f);
        apply(1, 15'd0, 3'd0, 3'd0, r, f, 1, 0, 5'd0, 0, 1);
    endtask

    function automatic bit [4:0] small_idx();
        return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    // Monitor: compare every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_stall", {29'd0, c_sel, id_stall, pc_stall}, e.stall ? 32'd7 : 32'd0);
            chk("mon_cnt", {29'd0, pending_cnt}, e.cnt);
        end
    end

    initial begin
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NREGS; r++)
                pend[f][r] = 1'b0;

        // Reset with a long op presented: stalls must be forced low.
        id_valid = 1'b1; id_long = 1'b1; id_rd = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk_stall("reset_stall", 0);
        chk_cnt("reset_cnt", 0);
        tick();

        // Load-use on x5.
        issue_op(5'd5, 0); chk_stall("issue_x5", 0); tick();
        apply(1, pk(5, 0, 0), 3'b001, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1);
        chk_cnt("cnt_x5", 1); chk_stall("raw_x5", 1); tick();
        apply(1, pk(5, 0, 0), 3'b001, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1);
        chk_stall("raw_x5_hold", 1); tick();
        apply(1, pk(5, 0, 0), 3'b001, 3'b000, 5'd0, 0, 0, 1, 5'd5, 0, 1);
        chk_stall("raw_x5_wb_cycle", !BYP); tick();
        apply(1, pk(5, 0, 0), 3'b001, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1);
        chk_stall("raw_x5_released", 0); chk_cnt("cnt_x5_done", 0); tick();

        // File select: f5 pending, x5 reads free, rs3 float read stalls.
        issue_op(5'd5, 1); tick();
        apply(1, pk(5, 5, 0), 3'b011, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1);
        chk_stall("int_x5_vs_f5", 0); chk_cnt("cnt_f5", 1); tick();
        apply(1, pk(0, 0, 5), 3'b100, 3'b100, 5'd0, 0, 0, 0, 5'd0, 0, 1);
        chk_stall("rs3_f5", 1); tick();
        wb(5'd5, 1); tick();

        // x0 is never pending.
        issue_op(5'd0, 0); chk_stall("issue_x0", 0); tick();
        apply(1, pk(0, 0, 0), 3'b001, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1);
        chk_cnt("cnt_x0", 0); chk_stall("read_x0", 0); tick();

        // Capacity.
        for (int k = 1; k <= 4; k++) begin
            issue_op(5'(k), 0); tick();
        end
        issue_op(5'd6, 0); chk_cnt("cnt_full", 4); chk_stall("cap_stall", 1); tick();
        apply(1, 15'd0, 3'd0, 3'd0, 5'd6, 0, 1, 1, 5'd2, 0, 1);
        chk_stall("cap_wb_cycle", !BYP); tick();
        if (!BYP) begin
            issue_op(5'd6, 0); chk_cnt("cnt_after_wb_x2", 3); chk_stall("x6_issues", 0); tick();
        end
        idle(); chk_cnt("cnt_refull", 4); tick();
        wb(5'd1, 0); tick(); wb(5'd3, 0); tick(); wb(5'd4, 0); tick(); wb(5'd6, 0); tick();
        idle(); chk_cnt("cnt_drained", 0); tick();

        // WAW on x7.
        issue_op(5'd7, 0); tick();
        issue_op(5'd7, 0); chk_stall("waw_x7", 1); chk_cnt("cnt_x7", 1); tick();
        apply(1, 15'd0, 3'd0, 3'd0, 5'd7, 0, 1, 1, 5'd7, 0, 1);
        chk_stall("waw_x7_wb_cycle", !BYP); tick();
        if (!BYP) begin
            issue_op(5'd7, 0); chk_stall("waw_x7_release", 0); chk_cnt("cnt_x7_cleared", 0); tick();
        end
        idle(); chk_cnt("cnt_x7_reissued", 1); tick();
        wb(5'd9, 0); tick();
        idle(); chk_cnt("cnt_wb_nonpending", 1); tick();
        wb(5'd7, 0); tick();

        // Reset mid-operation.
        issue_op(5'd10, 0); tick(); issue_op(5'd11, 0); tick(); issue_op(5'd12, 1); tick();
        apply(1, pk(10, 0, 0), 3'b001, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 0);
        chk_cnt("cnt_before_reset", 3); chk_stall("stall_forced_in_reset", 0); tick();
        apply(1, pk(10, 0, 0), 3'b001, 3'b000, 5'd0, 0, 0, 0, 5'd0, 0, 1);
        chk_stall("stall_after_reset", 0); chk_cnt("cnt_after_reset", 0); tick();
        wb(5'd10, 0); tick();
        idle(); chk_cnt("late_wb_ignored", 0); tick();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            apply($urandom_range(0, 3) != 0,
                  pk(small_idx(), small_idx(), small_idx()),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  small_idx(), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)), small_idx(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) != 0);
            tick();
        end
        idle(); tick();
        idle(); tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
